// File: rtl/bit_serializer_if.sv
// bit_serializer_if: load/ready handshake and serial output bundle for bit_serializer.
//   load       master->slave  request to capture data (taken only while ready=1)
//   data       master->slave  parallel pattern, bit WIDTH-1 sent first
//   ready      slave->master  serializer idle, load will be accepted on the next edge
//   b          slave->master  registered serial bit
//   bit_strobe slave->master  registered, high on the first cycle of each bit period
//   busy       slave->master  word in progress
//   done       slave->master  one-cycle pulse on the last cycle of the last bit
interface bit_serializer_if #(
   parameter int unsigned WIDTH = 8
);
   logic             load;
   logic [WIDTH-1:0] data;
   logic             ready;
   logic             b;
   logic             bit_strobe;
   logic             busy;
   logic             done;

   modport master (
      output load, data,
      input  ready, b, bit_strobe, busy, done
   );

   modport slave (
      input  load, data,
      output ready, b, bit_strobe, busy, done
   );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: captures a WIDTH-bit pattern on a load/ready handshake and shifts it out
// MSB-first on bus.b, each bit held for DIV clock cycles, with a per-bit strobe and an
// end-of-word done pulse so downstream detector output can be aligned to its input bit.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   rpt  (only with BIT_SERIALIZER_REPEAT_EN) replay the captured word when done is high
//   bus  bit_serializer_if.slave: load, data in; ready, b, bit_strobe, busy, done out
//
// Optional feature macro: BIT_SERIALIZER_REPEAT_EN (adds rpt and a captured-word register).
module bit_serializer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 1
) (
   input logic clk,
   input logic rst,
`ifdef BIT_SERIALIZER_REPEAT_EN
   input logic rpt,
`endif
   bit_serializer_if.slave bus
);

   localparam int unsigned BW = $clog2(WIDTH);
   localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0] BitLast = BW'(WIDTH - 1);
   localparam logic [DW-1:0] DivLast = DW'(DIV - 1);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e           state_q, state_d;
   // MSB of the shift register is the serial output; it is kept all-zero while idle.
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DW-1:0]    div_cnt_q, div_cnt_d;
   logic             strobe_q, strobe_d;
   logic             div_last;
   logic             done;
`ifdef BIT_SERIALIZER_REPEAT_EN
   logic [WIDTH-1:0] word_q, word_d;
`endif

   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      bit_cnt_d = bit_cnt_q;
      div_cnt_d = div_cnt_q;
      strobe_d  = 1'b0;
`ifdef BIT_SERIALIZER_REPEAT_EN
      word_d    = word_q;
`endif
      // With DIV=1 DivLast is 0 and the div counter never leaves 0.
      div_last  = (div_cnt_q == DivLast);
      done      = (state_q == StShift) && (bit_cnt_q == '0) && div_last;

      unique case (state_q)
         StIdle: begin
            if (bus.load) begin
               state_d   = StShift;
               sreg_d    = bus.data;
               bit_cnt_d = BitLast;
               div_cnt_d = '0;
               strobe_d  = 1'b1;
`ifdef BIT_SERIALIZER_REPEAT_EN
               word_d    = bus.data;
`endif
            end
         end
         StShift: begin
            if (!div_last) begin
               div_cnt_d = div_cnt_q + 1'b1;
            end else if (bit_cnt_q != '0) begin
               sreg_d    = {sreg_q[WIDTH-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q - 1'b1;
               div_cnt_d = '0;
               strobe_d  = 1'b1;
`ifdef BIT_SERIALIZER_REPEAT_EN
            end else if (rpt) begin
               // Seamless replay: no idle gap, ready stays low.
               sreg_d    = word_q;
               bit_cnt_d = BitLast;
               div_cnt_d = '0;
               strobe_d  = 1'b1;
`endif
            end else begin
               state_d   = StIdle;
               sreg_d    = '0;
               div_cnt_d = '0;
            end
         end
         default: begin
            state_d = StIdle;
            sreg_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         sreg_q    <= '0;
         bit_cnt_q <= '0;
         div_cnt_q <= '0;
         strobe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         bit_cnt_q <= bit_cnt_d;
         div_cnt_q <= div_cnt_d;
         strobe_q  <= strobe_d;
      end
   end

`ifdef BIT_SERIALIZER_REPEAT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end
`endif

   assign bus.ready      = (state_q == StIdle);
   assign bus.busy       = (state_q == StShift);
   assign bus.b          = sreg_q[WIDTH-1];
   assign bus.bit_strobe = strobe_q;
   assign bus.done       = done;

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench for bit_serializer. Stimulus pushes the expected
// per-cycle (b, bit_strobe, done) sequence of each accepted word into a queue; per-DUT
// monitors pop and compare every busy cycle and check idle outputs otherwise.
//   u_dut0: WIDTH=8 DIV=1   u_dut1: WIDTH=8 DIV=3   u_dut2: WIDTH=4 DIV=1 (repeat build only)
module tb_bit_serializer;

   typedef struct packed {
      logic b;
      logic strobe;
      logic done;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   bit_serializer_if #(.WIDTH(8)) i0 ();
   bit_serializer_if #(.WIDTH(8)) i1 ();
   bit_serializer_if #(.WIDTH(4)) i2 ();

   bit_serializer #(.WIDTH(8), .DIV(1)) u_dut0 (
      .clk (clk),
      .rst (rst),
`ifdef BIT_SERIALIZER_REPEAT_EN
      .rpt (1'b0),
`endif
      .bus (i0)
   );

   bit_serializer #(.WIDTH(8), .DIV(3)) u_dut1 (
      .clk (clk),
      .rst (rst),
`ifdef BIT_SERIALIZER_REPEAT_EN
      .rpt (1'b0),
`endif
      .bus (i1)
   );

`ifdef BIT_SERIALIZER_REPEAT_EN
   logic rpt2 = 1'b0;
   bit_serializer #(.WIDTH(4), .DIV(1)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .rpt (rpt2),
      .bus (i2)
   );
`else
   assign i2.ready      = 1'b1;
   assign i2.b          = 1'b0;
   assign i2.bit_strobe = 1'b0;
   assign i2.busy       = 1'b0;
   assign i2.done       = 1'b0;
`endif

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Expected outputs for bit i (from MSB), cycle j within that bit.
   function automatic exp_t gen(int w, int d, logic [31:0] data, int i, int j);
      exp_t e;
      e.b      = data[w-1-i];
      e.strobe = (j == 0);
      e.done   = (i == w - 1) && (j == d - 1);
      return e;
   endfunction

   function automatic void check_cycle(string tag, logic busy, logic ready, logic b,
                                       logic strobe, logic done, logic have, exp_t e);
      if (busy) begin
         chk({tag, " busy with word queued"}, have, 1);
         if (have) begin
            chk({tag, " b"}, b, e.b);
            chk({tag, " bit_strobe"}, strobe, e.strobe);
            chk({tag, " done"}, done, e.done);
            chk({tag, " ready while busy"}, ready, 0);
         end
      end else begin
         chk({tag, " idle b"}, b, 0);
         chk({tag, " idle bit_strobe"}, strobe, 0);
         chk({tag, " idle done"}, done, 0);
         chk({tag, " idle ready"}, ready, 1);
      end
   endfunction

   // Monitors
   always @(negedge clk) begin
      exp_t e;
      logic have;
      e = '0;
      if (rst) begin
         have = (q0.size() != 0);
         if (i0.busy && have) e = q0.pop_front();
         check_cycle("dut0", i0.busy, i0.ready, i0.b, i0.bit_strobe, i0.done, have, e);
         have = (q1.size() != 0);
         if (i1.busy && have) e = q1.pop_front();
         check_cycle("dut1", i1.busy, i1.ready, i1.b, i1.bit_strobe, i1.done, have, e);
`ifdef BIT_SERIALIZER_REPEAT_EN
         have = (q2.size() != 0);
         if (i2.busy && have) e = q2.pop_front();
         check_cycle("dut2", i2.busy, i2.ready, i2.b, i2.bit_strobe, i2.done, have, e);
`endif
      end
   end

   task automatic send0(input logic [7:0] d);
      int n = 0;
      while (!i0.ready && n < 100) begin @(posedge clk); #1; n++; end
      chk("dut0 ready before load", i0.ready, 1);
      i0.load = 1'b1;
      i0.data = d;
      @(posedge clk);
      for (int i = 0; i < 8; i++) q0.push_back(gen(8, 1, d, i, 0));
      #1 i0.load = 1'b0;
   endtask

   task automatic wait_idle0();
      int n = 0;
      while (i0.busy && n < 200) begin @(posedge clk); #1; n++; end
      chk("dut0 returns idle in time", i0.busy, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      time t_acc[2];
      int  acc;
      logic r;
      i0.load = 1'b0; i0.data = '0;
      i1.load = 1'b0; i1.data = '0;
      i2.load = 1'b0; i2.data = '0;
      #2;
      chk("reset ready", i0.ready, 1);
      chk("reset busy", i0.busy, 0);
      chk("reset b", i0.b, 0);
      chk("reset bit_strobe", i0.bit_strobe, 0);
      chk("reset done", i0.done, 0);
      #10 rst = 1'b1;
      @(posedge clk); #1;

      // Word 1000_1001, DIV=1: done only in cycle 7, ready/b=0 from edge 8
      send0(8'b1000_1001);
      repeat (7) @(posedge clk);
      #1;
      chk("dut0 done in cycle 7", i0.done, 1);
      chk("dut0 b in cycle 7", i0.b, 1);
      @(posedge clk); #1;
      chk("dut0 ready after word", i0.ready, 1);
      chk("dut0 b after word", i0.b, 0);
      wait_idle0();

      // Load while busy is ignored
      send0(8'hFF);
      repeat (3) @(posedge clk);
      #1 i0.load = 1'b1; i0.data = 8'h00;
      @(posedge clk); #1 i0.load = 1'b0;
      wait_idle0();

      // Asynchronous reset mid-word
      send0(8'hAA);
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      q0.delete();
      #1;
      chk("async reset b", i0.b, 0);
      chk("async reset busy", i0.busy, 0);
      chk("async reset bit_strobe", i0.bit_strobe, 0);
      chk("async reset done", i0.done, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      send0(8'h81);
      wait_idle0();

      // Back-to-back with load held high
      i0.load = 1'b1;
      i0.data = 8'hC3;
      acc = 0;
      for (int n = 0; n < 40 && acc < 2; n++) begin
         @(negedge clk);
         r = i0.ready;
         @(posedge clk);
         if (r) begin
            for (int i = 0; i < 8; i++) q0.push_back(gen(8, 1, 32'hC3, i, 0));
            t_acc[acc] = $time;
            acc++;
         end
      end
      #1 i0.load = 1'b0;
      chk("back-to-back accepts", acc, 2);
      if (acc == 2) chk("back-to-back gap cycles", 32'((t_acc[1] - t_acc[0]) / 10), 9);
      wait_idle0();

      // DIV=3, 8'hA5
      i1.load = 1'b1;
      i1.data = 8'hA5;
      @(posedge clk);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 3; j++) q1.push_back(gen(8, 3, 32'hA5, i, j));
      #1 i1.load = 1'b0;
      for (int n = 0; n < 200 && i1.busy; n++) begin @(posedge clk); #1; end
      chk("dut1 returns idle in time", i1.busy, 0);

`ifdef BIT_SERIALIZER_REPEAT_EN
      // Repeat: 1011 three times with no gap, rpt dropped during the third word
      rpt2 = 1'b1;
      i2.load = 1'b1;
      i2.data = 4'b1011;
      @(posedge clk);
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 4; i++) q2.push_back(gen(4, 1, 32'hB, i, 0));
      #1 i2.load = 1'b0;
      repeat (8) @(posedge clk);
      #1 rpt2 = 1'b0;
      for (int n = 0; n < 200 && i2.busy; n++) begin @(posedge clk); #1; end
      chk("dut2 returns idle in time", i2.busy, 0);
`endif

      @(posedge clk); #1;
      chk("dut0 queue drained", q0.size(), 0);
      chk("dut1 queue drained", q1.size(), 0);
      chk("dut2 queue drained", q2.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Upstream stage of the serial pattern detector. Accepts a parallel bit pattern over a load/ready handshake and shifts it out MSB-first on a single-bit line `b`, one bit per DIV clock cycles, so the detector consumes one bit per sample. Also provides a per-bit strobe and an end-of-word pulse, so a bench or controller can align detector output `w` to the bit that caused it.

## Interface
- WIDTH, 8, pattern length in bits (≥2)
- DIV, 1, clock cycles each bit is held on `b` (≥1)

- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- load  in  1  request to capture `data`; accepted only when `ready`=1
- data  in  WIDTH  pattern; bit WIDTH-1 sent first
- ready  out  1  high in IDLE; load accepted on a clk edge where load&ready
- b  out  1  serial bit to detector; registered
- bit_strobe  out  1  high on first cycle of each bit period; registered
- busy  out  1  high while a word is being shifted
- done  out  1  one-cycle pulse on last cycle of last bit

## Operation
- States: IDLE, SHIFT.
- IDLE: ready=1, busy=0, b=0, bit_strobe=0, done=0.
- IDLE→SHIFT on edge with load=1: shift register ← data, bit counter ← WIDTH-1, div counter ← 0; b ← data[WIDTH-1], bit_strobe ← 1.
- SHIFT: div counter increments each cycle. When it reaches DIV-1:
  - if bit counter ≠ 0: shift left, b ← next bit, bit counter −1, div counter ← 0, bit_strobe ← 1 for that cycle;
  - if bit counter = 0: → IDLE, b ← 0.
- done is combinational from state: SHIFT & bit counter=0 & div counter=DIV-1.
- load while busy: ignored, no effect on shift register or outputs. data is sampled only on the accepting edge; later changes are ignored.
- DIV=1: div counter is a constant 0. Every SHIFT cycle advances a bit and bit_strobe stays high for the whole word.
- Counter widths: bit counter $clog2(WIDTH), div counter max($clog2(DIV),1); no wrap beyond the stated terminal values.

## Timing
- Reset (rst=0, asynchronous, immediate): state=IDLE, b=0, bit_strobe=0, busy=0, done=0, ready=1, shift register=0. Holds while rst=0.
- Reset mid-word: word is abandoned; no done pulse. After release, a new load is accepted on the first edge.
- Load accepted at edge k:
  - bit i (0-based from MSB) on `b` from edge k+i·DIV to edge k+(i+1)·DIV;
  - busy=1 for WIDTH·DIV cycles;
  - done high in the cycle before edge k+WIDTH·DIV;
  - ready=1 after that edge.
- Minimum word-to-word gap: one IDLE cycle with b=0. The earliest next accept is edge k+WIDTH·DIV+1.

## Configuration
- BIT_SERIALIZER_REPEAT_EN defined: adds input port `rpt` (1 bit).
  - If rpt=1 on the cycle done is high, the block stays in SHIFT and reloads the originally captured word. Bit counter ← WIDTH-1, b ← word MSB, bit_strobe=1.
  - This gives a seamless loop with no gap. done pulses once per word; ready stays 0.
  - The captured word is held in a separate WIDTH-bit register.
- Undefined: no `rpt` port and no extra register; behaviour is exactly single-shot as above.

## Test plan
- WIDTH=8, DIV=1, load data=8'b1000_1001 at edge 0 -> b=1,0,0,0,1,0,0,1 in cycles 0–7; done=1 in cycle 7 only; ready=1 and b=0 from edge 8.
- WIDTH=8, DIV=3, data=8'hA5 -> each bit held 3 cycles; bit_strobe pulses at cycles 0,3,…,21; busy for 24 cycles.
- Load 8'hFF accepted, then load=1 with data=8'h00 at cycle 3 -> ignored; b stays 1 for all 8 bits.
- rst=0 asynchronously at cycle 4 of a word -> b, busy, bit_strobe drop to 0 immediately; no done; after release, load 8'h81 serialises correctly.
- Back-to-back: hold load=1 with 8'hC3 -> second word accepted exactly one cycle after ready reasserts; b=0 in the gap cycle.
- REPEAT_EN, rpt=1, data=4'b1011 (WIDTH=4) -> b=1,0,1,1,1,0,1,1,… with no gap; done every 4 cycles; rpt=0 -> stops after current word.
